// File: rtl/aw_push_ctrl.sv
// aw_push_ctrl: AXI AW channel front end for the write side of an async AW FIFO.
// A two-entry in-order buffer (main + skid) decouples awready_o from the FIFO
// full flag, and an outstanding-write counter limits in-flight writes to MAX_OUT.
// Optional feature: define AW_4K_CHECK_EN to enable the sticky 4KB-crossing
// error flag for INCR bursts; without it err_4k_o is tied to 0.
module aw_push_ctrl #(
    parameter int MAX_OUT = 4
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic [3:0]  awid_i,
    input  logic [31:0] awaddr_i,
    input  logic [3:0]  awlen_i,
    input  logic [2:0]  awsize_i,
    input  logic [1:0]  awburst_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic        bvalid_i,
    input  logic        bready_i,
    output logic        fifo_push_o,
    output logic [44:0] fifo_data_o,
    input  logic        fifo_full_i,
    output logic [3:0]  outstanding_o,
    output logic        err_4k_o
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

    logic        main_valid;
    logic [44:0] main_data;
    logic        skid_valid;
    logic [44:0] skid_data;
    logic [3:0]  count;

    logic        accept;
    logic        drain;
    logic        b_take;
    logic [44:0] aw_word;

    // Ready depends only on registered state, so there is no combinational
    // path from awvalid_i or fifo_full_i to awready_o.
    assign awready_o     = !skid_valid && (count < MAX_CNT);
    assign accept        = awvalid_i && awready_o;
    // Push is masked while reset is held so no word leaves during the reset cycle.
    assign fifo_push_o   = main_valid && !w_rst;
    assign fifo_data_o   = main_data;
    assign drain         = fifo_push_o && !fifo_full_i;
    assign b_take        = bvalid_i && bready_i && (count != 4'd0);
    assign outstanding_o = count;
    assign aw_word       = {awid_i, awaddr_i, awlen_i, awsize_i, awburst_i};

    // Main/skid buffer: keeps acceptance order while the FIFO back-pressures.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order races.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            // NOTE: data registers are reset only because fifo_data_o must read
            // 0 after reset; payload storage normally needs no reset.
            main_data  <= '0;
            skid_data  <= '0;
        end else if (drain) begin
            if (skid_valid) begin
                // Skid is full so awready_o was low; no accept can coincide.
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data  <= aw_word;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (main_valid) begin
                skid_data  <= aw_word;
                skid_valid <= 1'b1;
            end else begin
                main_data  <= aw_word;
                main_valid <= 1'b1;
            end
        end
    end

    // Outstanding counter: +1 per AW accept, -1 per B handshake, saturating at 0.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            count <= 4'd0;
        end else if (accept && !b_take) begin
            count <= count + 4'd1;
        end else if (b_take && !accept) begin
            count <= count - 4'd1;
        end
    end

`ifdef AW_4K_CHECK_EN
    logic [31:0] burst_bytes;
    logic [31:0] last_addr;
    logic        crosses_4k;

    assign burst_bytes = (32'(awlen_i) + 32'd1) << awsize_i;
    assign last_addr   = awaddr_i + burst_bytes - 32'd1;
    assign crosses_4k  = (awburst_i == 2'b01) && (awaddr_i[31:12] != last_addr[31:12]);

    logic err_4k;

    // Sticky flag set one cycle after accepting an INCR burst that crosses 4KB.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            err_4k <= 1'b0;
        end else if (accept && crosses_4k) begin
            err_4k <= 1'b1;
        end
    end

    assign err_4k_o = err_4k;
`else
    assign err_4k_o = 1'b0;
`endif

endmodule

// File: tb/tb_aw_push_ctrl.sv
// Directed testbench for aw_push_ctrl (MAX_OUT = 4). Checks both builds:
// the 4KB error expectation follows AW_4K_CHECK_EN.
module tb_aw_push_ctrl;

`ifdef AW_4K_CHECK_EN
    localparam logic EXP_4K = 1'b1;
`else
    localparam logic EXP_4K = 1'b0;
`endif

    logic        w_clk = 1'b0;
    logic        w_rst;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic        bvalid;
    logic        bready;
    logic        fifo_push;
    logic [44:0] fifo_data;
    logic        fifo_full;
    logic [3:0]  outstanding;
    logic        err_4k;

    int total = 0;
    int bad   = 0;

    aw_push_ctrl #(.MAX_OUT(4)) dut (
        .w_clk        (w_clk),
        .w_rst        (w_rst),
        .awid_i       (awid),
        .awaddr_i     (awaddr),
        .awlen_i      (awlen),
        .awsize_i     (awsize),
        .awburst_i    (awburst),
        .awvalid_i    (awvalid),
        .awready_o    (awready),
        .bvalid_i     (bvalid),
        .bready_i     (bready),
        .fifo_push_o  (fifo_push),
        .fifo_data_o  (fifo_data),
        .fifo_full_i  (fifo_full),
        .outstanding_o(outstanding),
        .err_4k_o     (err_4k)
    );

    always #5 w_clk = ~w_clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic drive_aw(input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
        awid    = id;
        awaddr  = addr;
        awlen   = len;
        awsize  = size;
        awburst = burst;
        awvalid = 1'b1;
    endtask

    function automatic logic [44:0] pack(input logic [3:0] id, input logic [31:0] addr,
                                         input logic [3:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
        return {id, addr, len, size, burst};
    endfunction

    task automatic drain_b(input int n);
        bvalid = 1'b1;
        bready = 1'b1;
        repeat (n) tick();
        bvalid = 1'b0;
        bready = 1'b0;
    endtask

    task automatic test_reset();
        w_rst = 1'b1;
        repeat (2) tick();
        w_rst = 1'b0;
        total++; if (awready !== 1'b1) begin bad++; $display("FAIL reset_awready got=%b exp=1", awready); end
        total++; if (fifo_push !== 1'b0) begin bad++; $display("FAIL reset_push got=%b exp=0", fifo_push); end
        total++; if (fifo_data !== 45'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", fifo_data); end
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", outstanding); end
        total++; if (err_4k !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_4k); end
    endtask

    task automatic test_single();
        drive_aw(4'h3, 32'h0000_1000, 4'h3, 3'h2, 2'h1);
        tick();
        awvalid = 1'b0;
        total++; if (fifo_push !== 1'b1) begin bad++; $display("FAIL single_push got=%b exp=1", fifo_push); end
        total++; if (fifo_data !== 45'h6000_0200_069) begin bad++; $display("FAIL single_data got=%h exp=%h", fifo_data, 45'h6000_0200_069); end
        total++; if (outstanding !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", outstanding); end
        tick();
        total++; if (fifo_push !== 1'b0) begin bad++; $display("FAIL single_push_done got=%b exp=0", fifo_push); end
        total++; if (err_4k !== 1'b0) begin bad++; $display("FAIL single_no_4k got=%b exp=0", err_4k); end
        drain_b(1);
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL single_b_count got=%0d exp=0", outstanding); end
    endtask

    task automatic test_backpressure();
        logic [44:0] wa, wb, wc;
        wa = pack(4'hA, 32'h0000_2000, 4'h0, 3'h2, 2'h1);
        wb = pack(4'hB, 32'h0000_3000, 4'h1, 3'h2, 2'h1);
        wc = pack(4'hC, 32'h0000_4000, 4'h2, 3'h2, 2'h1);
        fifo_full = 1'b1;
        drive_aw(4'hA, 32'h0000_2000, 4'h0, 3'h2, 2'h1);
        tick();
        total++; if (awready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_a got=%b exp=1", awready); end
        drive_aw(4'hB, 32'h0000_3000, 4'h1, 3'h2, 2'h1);
        tick();
        total++; if (awready !== 1'b0) begin bad++; $display("FAIL bp_ready_after_b got=%b exp=0", awready); end
        drive_aw(4'hC, 32'h0000_4000, 4'h2, 3'h2, 2'h1);
        repeat (2) tick();
        total++; if (fifo_push !== 1'b1 || fifo_data !== wa) begin bad++; $display("FAIL bp_hold_a push=%b data=%h exp=%h", fifo_push, fifo_data, wa); end
        total++; if (outstanding !== 4'd2) begin bad++; $display("FAIL bp_count got=%0d exp=2", outstanding); end
        fifo_full = 1'b0;
        tick();
        total++; if (fifo_push !== 1'b1 || fifo_data !== wb) begin bad++; $display("FAIL bp_second_b push=%b data=%h exp=%h", fifo_push, fifo_data, wb); end
        total++; if (awready !== 1'b1) begin bad++; $display("FAIL bp_ready_reopen got=%b exp=1", awready); end
        tick();
        awvalid = 1'b0;
        total++; if (fifo_push !== 1'b1 || fifo_data !== wc) begin bad++; $display("FAIL bp_third_c push=%b data=%h exp=%h", fifo_push, fifo_data, wc); end
        total++; if (outstanding !== 4'd3) begin bad++; $display("FAIL bp_count_c got=%0d exp=3", outstanding); end
        tick();
        total++; if (fifo_push !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", fifo_push); end
        drain_b(3);
    endtask

    task automatic test_max_out();
        for (int i = 0; i < 4; i++) begin
            drive_aw(4'(i), 32'h0001_0000 + 32'(i * 64), 4'h0, 3'h2, 2'h1);
            tick();
        end
        awvalid = 1'b0;
        total++; if (awready !== 1'b0) begin bad++; $display("FAIL max_ready got=%b exp=0", awready); end
        total++; if (outstanding !== 4'd4) begin bad++; $display("FAIL max_count got=%0d exp=4", outstanding); end
        drain_b(1);
        total++; if (awready !== 1'b1) begin bad++; $display("FAIL max_ready_after_b got=%b exp=1", awready); end
        total++; if (outstanding !== 4'd3) begin bad++; $display("FAIL max_count_after_b got=%0d exp=3", outstanding); end
        drain_b(3);
    endtask

    task automatic test_simultaneous();
        drive_aw(4'h1, 32'h0000_5000, 4'h0, 3'h0, 2'h1);
        repeat (2) tick();
        total++; if (outstanding !== 4'd2) begin bad++; $display("FAIL sim_setup got=%0d exp=2", outstanding); end
        bvalid = 1'b1;
        bready = 1'b1;
        tick();
        awvalid = 1'b0;
        bvalid  = 1'b0;
        bready  = 1'b0;
        total++; if (outstanding !== 4'd2) begin bad++; $display("FAIL sim_aw_b got=%0d exp=2", outstanding); end
        drain_b(2);
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL sim_drain got=%0d exp=0", outstanding); end
        drain_b(2);
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL sim_b_at_zero got=%0d exp=0", outstanding); end
    endtask

    task automatic test_4k();
        logic [44:0] w4k;
        w4k = pack(4'h5, 32'h0000_0FF8, 4'h3, 3'h2, 2'h1);
        drive_aw(4'h5, 32'h0000_0FF8, 4'h3, 3'h2, 2'h1);
        tick();
        awvalid = 1'b0;
        total++; if (err_4k !== EXP_4K) begin bad++; $display("FAIL 4k_set got=%b exp=%b", err_4k, EXP_4K); end
        total++; if (fifo_push !== 1'b1 || fifo_data !== w4k) begin bad++; $display("FAIL 4k_forward push=%b data=%h exp=%h", fifo_push, fifo_data, w4k); end
        repeat (3) tick();
        total++; if (err_4k !== EXP_4K) begin bad++; $display("FAIL 4k_sticky got=%b exp=%b", err_4k, EXP_4K); end
        drain_b(1);
    endtask

    task automatic test_reset_mid();
        fifo_full = 1'b1;
        drive_aw(4'h7, 32'h0000_6000, 4'h0, 3'h2, 2'h1);
        tick();
        drive_aw(4'h8, 32'h0000_7000, 4'h0, 3'h2, 2'h1);
        tick();
        awvalid = 1'b0;
        total++; if (awready !== 1'b0) begin bad++; $display("FAIL rst_mid_both_full got=%b exp=0", awready); end
        fifo_full = 1'b0;
        w_rst = 1'b1;
        #1;
        total++; if (fifo_push !== 1'b0) begin bad++; $display("FAIL rst_mid_no_push got=%b exp=0", fifo_push); end
        tick();
        w_rst = 1'b0;
        total++; if (fifo_push !== 1'b0) begin bad++; $display("FAIL rst_mid_push got=%b exp=0", fifo_push); end
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL rst_mid_count got=%0d exp=0", outstanding); end
        total++; if (awready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", awready); end
        total++; if (err_4k !== 1'b0) begin bad++; $display("FAIL rst_mid_err got=%b exp=0", err_4k); end
        tick();
        total++; if (fifo_push !== 1'b0) begin bad++; $display("FAIL rst_mid_no_replay got=%b exp=0", fifo_push); end
    endtask

    initial begin
        w_rst     = 1'b1;
        awid      = '0;
        awaddr    = '0;
        awlen     = '0;
        awsize    = '0;
        awburst   = '0;
        awvalid   = 1'b0;
        bvalid    = 1'b0;
        bready    = 1'b0;
        fifo_full = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_max_out();
        test_simultaneous();
        test_4k();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
